trainer_stim_sequencer: RTL and testbench

Upstream stimulus and capture stage for the digital trainer kit gate block. Drives the gate block's `a`/`b` inputs through the four combinations 00, 01, 10, 11, either manually (debounced step button) or automatically (start pulse). Samples the seven gate outputs after a settle time and assembles them into a 28-bit truth table. Delivers the table downstream over a valid/ready handshake.

---
 rtl/trainer_stim_sequencer_pkg.sv | 31 +++
 rtl/trainer_stim_sequencer_if.sv | 12 +
 rtl/trainer_stim_sequencer_btn_debounce.sv | 46 ++++
 rtl/trainer_stim_sequencer.sv | 120 ++++++++++++
 tb/tb_trainer_stim_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/trainer_stim_sequencer_pkg.sv
// rtl/trainer_stim_sequencer_pkg.sv - shared types and constants for the trainer stimulus sequencer
package trainer_pkg;

  localparam int GATE_W = 7;
  localparam int ROWS   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DWELL,
    ST_WAIT_STEP,
    ST_PRESENT
  } state_t;

  // Bit position of each gate output within gates_in / a table row.
  typedef enum int {
    GATE_XNOR  = 0,
    GATE_XOR   = 1,
    GATE_NOR   = 2,
    GATE_NAND  = 3,
    GATE_NOT_A = 4,
    GATE_OR    = 5,
    GATE_AND   = 6
  } gate_pos_e;

  function automatic int row_lsb(input logic [1:0] row);
    return int'(row) * GATE_W;
  endfunction

endpackage

// File: rtl/trainer_stim_sequencer_if.sv
// rtl/trainer_stim_sequencer_if.sv - truth-table delivery handshake
interface trainer_stim_sequencer_if;
  import trainer_pkg::*;

  logic [ROWS*GATE_W-1:0] table_data;
  logic                   table_valid;
  logic                   table_ready;

  modport master (output table_data, output table_valid, input table_ready);
  modport slave  (input table_data, input table_valid, output table_ready);

endinterface

// File: rtl/trainer_stim_sequencer_btn_debounce.sv
// rtl/trainer_stim_sequencer_btn_debounce.sv - button synchroniser, debouncer and rising-edge pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any return to agreement restarts it, so short glitches die.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse    <= 1'b0;
    end else if (ena) begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      pulse   <= 1'b0;
      if (sync2_q != stable_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_q <= sync2_q;
          cnt_q    <= '0;
          pulse    <= sync2_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/trainer_stim_sequencer.sv
// rtl/trainer_stim_sequencer.sv - sweeps a/b through 00..11, captures gate outputs into a truth table
module trainer_stim_sequencer
  import trainer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 2,
  parameter int DWELL_CYCLES    = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              btn_step,
  input  logic              mode_auto,
  input  logic              start,
  input  logic [GATE_W-1:0] gates_in,
  output logic              a,
  output logic              b,
  output logic [1:0]        row_idx,
  output logic              busy,
  trainer_stim_sequencer_if.master tbl
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [1:0]             row_q;
  logic                   auto_q;
  logic [GATE_W-1:0]      sample_q;
  logic [ROWS*GATE_W-1:0] table_q;
  logic                   step;
  logic                   settle_done;
  logic                   dwell_done;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .raw   (btn_step),
    .pulse (step)
  );

  assign settle_done = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  assign dwell_done  = (cnt_q == CNT_W'(DWELL_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state_q <= ST_IDLE;
    else if (ena) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_SETTLE;
      ST_SETTLE:    if (settle_done) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (row_q == 2'(ROWS - 1)) state_d = ST_PRESENT;
        else if (auto_q)           state_d = ST_DWELL;
        else                       state_d = ST_WAIT_STEP;
      end
      ST_DWELL:     if (dwell_done) state_d = ST_SETTLE;
      ST_WAIT_STEP: if (step) state_d = ST_SETTLE;
      ST_PRESENT:   if (tbl.table_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy            = (state_q != ST_IDLE);
    tbl.table_valid = (state_q == ST_PRESENT);
  end

  // Row advances on the edge that enters SETTLE, so a/b (taken straight from
  // row_q) are registered and change exactly on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      row_q    <= 2'd0;
      auto_q   <= 1'b0;
      sample_q <= '0;
      table_q  <= '0;
    end else if (ena) begin
      case (state_q)
        ST_IDLE: if (start) begin
          auto_q  <= mode_auto;
          row_q   <= 2'd0;
          table_q <= '0;
          cnt_q   <= '0;
        end
        ST_SETTLE: begin
          if (settle_done) begin
            cnt_q    <= '0;
            sample_q <= gates_in;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_CAPTURE: table_q[row_lsb(row_q) +: GATE_W] <= sample_q;
        ST_DWELL: begin
          if (dwell_done) begin
            cnt_q <= '0;
            row_q <= row_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_STEP: if (step) row_q <= row_q + 2'd1;
        ST_PRESENT:   if (tbl.table_ready) row_q <= 2'd0;
        default: ;
      endcase
    end
  end

  assign a              = row_q[1];
  assign b              = row_q[0];
  assign row_idx        = row_q;
  assign tbl.table_data = table_q;

endmodule

// File: tb/tb_trainer_stim_sequencer.sv
// tb/tb_trainer_stim_sequencer.sv - randomized self-checking bench for trainer_stim_sequencer
module tb_trainer_stim_sequencer;
  import trainer_pkg::*;

  localparam int DB = 4;
  localparam int ST = 2;
  localparam int DW = 4;
  localparam int LAT = 1 + 4 * (ST + 1) + 3 * DW;

  logic clk = 1'b0;
  logic rst_n, ena, btn_step, mode_auto, start;
  logic [GATE_W-1:0] gates_in;
  logic a, b, busy;
  logic [1:0] row_idx;
  logic [27:0] lut;
  logic use_real;
  int total = 0;
  int bad = 0;

  trainer_stim_sequencer_if tif();

  trainer_stim_sequencer #(.DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(ST), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_step(btn_step), .mode_auto(mode_auto),
    .start(start), .gates_in(gates_in), .a(a), .b(b), .row_idx(row_idx), .busy(busy),
    .tbl(tif.master)
  );

  always #5 clk = ~clk;

  function automatic logic [GATE_W-1:0] real_gates(input logic ia, input logic ib);
    logic [GATE_W-1:0] g;
    g = '0;
    g[GATE_AND]   = ia & ib;
    g[GATE_OR]    = ia | ib;
    g[GATE_NOT_A] = ~ia;
    g[GATE_NAND]  = ~(ia & ib);
    g[GATE_NOR]   = ~(ia | ib);
    g[GATE_XOR]   = ia ^ ib;
    g[GATE_XNOR]  = ~(ia ^ ib);
    return g;
  endfunction

  // Gate block stand-in: either true logic gates or an arbitrary random response per input pair.
  always_comb gates_in = use_real ? real_gates(a, b) : lut[GATE_W * int'({a, b}) +: GATE_W];

  function automatic logic [27:0] exp_table();
    logic [27:0] e;
    logic [1:0] r2;
    for (int r = 0; r < ROWS; r++) begin
      r2 = 2'(r);
      e[GATE_W*r +: GATE_W] = use_real ? real_gates(r2[1], r2[0]) : lut[GATE_W*r +: GATE_W];
    end
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; btn_step = 1'b0; start = 1'b0; tif.table_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the cycle index (start cycle = 0) at which table_valid is first seen.
  task automatic wait_valid(input int bound, input bit rand_ena, output int cycles, output int lows);
    int n = 0;
    lows = 0;
    while (tif.table_valid !== 1'b1 && n < bound) begin
      ena = rand_ena ? ($urandom_range(3) != 0) : 1'b1;
      @(negedge clk);
      if (!ena) lows++;
      n++;
    end
    ena = 1'b1;
    cycles = n + 1;
  endtask

  task automatic press(input int high_cycles, input int low_cycles);
    btn_step = 1'b1;
    repeat (high_cycles) @(negedge clk);
    btn_step = 1'b0;
    repeat (low_cycles) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (a !== 1'b0) begin bad++; $display("FAIL reset_a got %b want 0", a); end
    total++; if (b !== 1'b0) begin bad++; $display("FAIL reset_b got %b want 0", b); end
    total++; if (row_idx !== 2'd0) begin bad++; $display("FAIL reset_row got %0d want 0", row_idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (tif.table_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", tif.table_valid); end
    total++; if (tif.table_data !== 28'd0) begin bad++; $display("FAIL reset_data got %h want 0", tif.table_data); end
  endtask

  task automatic test_auto();
    int cyc, lows;
    use_real = 1'b1; mode_auto = 1'b1; tif.table_ready = 1'b1;
    start_pulse();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL auto_busy got %b want 1", busy); end
    wait_valid(200, 1'b0, cyc, lows);
    total++; if (cyc !== LAT) begin bad++; $display("FAIL auto_latency got %0d want %0d", cyc, LAT); end
    total++; if (tif.table_data !== exp_table()) begin bad++; $display("FAIL auto_data got %h want %h", tif.table_data, exp_table()); end
    total++; if ({a, b} !== 2'b11) begin bad++; $display("FAIL auto_ab got %b want 11", {a, b}); end
    @(negedge clk);
    tif.table_ready = 1'b0;
    total++; if (tif.table_valid !== 1'b0) begin bad++; $display("FAIL auto_valid_drop got %b want 0", tif.table_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL auto_idle_busy got %b want 0", busy); end
    total++; if (row_idx !== 2'd0) begin bad++; $display("FAIL auto_idle_row got %0d want 0", row_idx); end
  endtask

  task automatic test_random_auto();
    int cyc, lows;
    use_real = 1'b0; mode_auto = 1'b1;
    for (int it = 0; it < 5; it++) begin
      lut = 28'($urandom());
      start_pulse();
      wait_valid(400, 1'b1, cyc, lows);
      total++; if (cyc !== LAT + lows) begin bad++; $display("FAIL rand_latency[%0d] got %0d want %0d", it, cyc, LAT + lows); end
      total++; if (tif.table_data !== exp_table()) begin bad++; $display("FAIL rand_data[%0d] got %h want %h", it, tif.table_data, exp_table()); end
      tif.table_ready = 1'b1;
      @(negedge clk);
      tif.table_ready = 1'b0;
      total++; if (tif.table_valid !== 1'b0) begin bad++; $display("FAIL rand_drop[%0d] got %b want 0", it, tif.table_valid); end
    end
  endtask

  task automatic test_manual();
    logic [27:0] held;
    use_real = 1'b0; lut = 28'($urandom()); mode_auto = 1'b0;
    start_pulse();
    repeat (10) @(negedge clk);
    total++; if (row_idx !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL man_wait got row=%0d busy=%b want row=0 busy=1", row_idx, busy); end
    for (int k = 1; k < ROWS; k++) begin
      btn_step = 1'b1;
      repeat (2 + DB) @(negedge clk);
      total++; if (row_idx !== 2'(k - 1)) begin bad++; $display("FAIL man_early[%0d] got %0d want %0d", k, row_idx, k - 1); end
      @(negedge clk);
      total++; if (row_idx !== 2'(k)) begin bad++; $display("FAIL man_step[%0d] got %0d want %0d", k, row_idx, k); end
      repeat (5) @(negedge clk);
      btn_step = 1'b0;
      repeat (2 + DB + 4) @(negedge clk);
    end
    total++; if (tif.table_valid !== 1'b1) begin bad++; $display("FAIL man_valid got %b want 1", tif.table_valid); end
    total++; if (tif.table_data !== exp_table()) begin bad++; $display("FAIL man_data got %h want %h", tif.table_data, exp_table()); end
    held = exp_table();
    press(8, 2 + DB + 4);
    total++; if (row_idx !== 2'd3 || tif.table_valid !== 1'b1) begin bad++; $display("FAIL man_extra got row=%0d valid=%b want row=3 valid=1", row_idx, tif.table_valid); end
    total++; if (tif.table_data !== held) begin bad++; $display("FAIL man_extra_data got %h want %h", tif.table_data, held); end
    tif.table_ready = 1'b1;
    @(negedge clk);
    tif.table_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL man_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_bounce();
    use_real = 1'b1; mode_auto = 1'b0;
    start_pulse();
    repeat (10) @(negedge clk);
    for (int g = 0; g < 3; g++) press(DB - 1, 3);
    total++; if (row_idx !== 2'd0) begin bad++; $display("FAIL bounce_glitch got %0d want 0", row_idx); end
    press(2 + DB + 6, 2 + DB + 6);
    total++; if (row_idx !== 2'd1) begin bad++; $display("FAIL bounce_one got %0d want 1", row_idx); end
    do_reset();
  endtask

  task automatic test_backpressure();
    int cyc, lows;
    logic [27:0] want;
    use_real = 1'b0; lut = 28'($urandom()); mode_auto = 1'b1;
    start_pulse();
    wait_valid(200, 1'b0, cyc, lows);
    want = exp_table();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++; if (tif.table_valid !== 1'b1 || tif.table_data !== want) begin
        bad++; $display("FAIL bp_hold[%0d] got valid=%b data=%h want valid=1 data=%h", i, tif.table_valid, tif.table_data, want);
      end
    end
    tif.table_ready = 1'b1;
    @(negedge clk);
    tif.table_ready = 1'b0;
    total++; if (tif.table_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_release got valid=%b busy=%b want 0 0", tif.table_valid, busy); end
  endtask

  task automatic test_reset_mid();
    int cyc, lows;
    use_real = 1'b0; lut = 28'($urandom()) | 28'h1; mode_auto = 1'b1;
    start_pulse();
    repeat (18) @(negedge clk);
    total++; if (row_idx !== 2'd2 || busy !== 1'b1) begin bad++; $display("FAIL rmid_pre got row=%0d busy=%b want row=2 busy=1", row_idx, busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({a, b, row_idx, busy, tif.table_valid} !== 6'd0 || tif.table_data !== 28'd0) begin
      bad++; $display("FAIL rmid_clear got ab=%b row=%0d busy=%b valid=%b data=%h want all 0", {a, b}, row_idx, busy, tif.table_valid, tif.table_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_pulse();
    wait_valid(200, 1'b0, cyc, lows);
    total++; if (cyc !== LAT) begin bad++; $display("FAIL rmid_latency got %0d want %0d", cyc, LAT); end
    total++; if (tif.table_data !== exp_table()) begin bad++; $display("FAIL rmid_data got %h want %h", tif.table_data, exp_table()); end
    tif.table_ready = 1'b1;
    @(negedge clk);
    tif.table_ready = 1'b0;
  endtask

  task automatic test_start_ena();
    int cyc, lows;
    use_real = 1'b0; lut = 28'($urandom()); mode_auto = 1'b1;
    start_pulse();
    @(negedge clk);
    start_pulse();
    mode_auto = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b0;
    repeat (10) @(negedge clk);
    ena = 1'b1;
    wait_valid(200, 1'b0, cyc, lows);
    total++; if (17 + cyc !== LAT + 10) begin bad++; $display("FAIL sena_latency got %0d want %0d", 17 + cyc, LAT + 10); end
    total++; if (tif.table_data !== exp_table()) begin bad++; $display("FAIL sena_data got %h want %h", tif.table_data, exp_table()); end
    mode_auto = 1'b1;
    tif.table_ready = 1'b1;
    @(negedge clk);
    tif.table_ready = 1'b0;
  endtask

  initial begin
    use_real = 1'b1; lut = '0; mode_auto = 1'b1;
    test_reset();
    test_auto();
    test_random_auto();
    test_manual();
    test_bounce();
    test_backpressure();
    test_reset_mid();
    test_start_ena();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
